// File: rtl/ctrl_decode_pipe.sv
// Registered MIPS decode stage with valid/ready flow control and SYSCALL/BREAK sequencing.
// Optional load-use interlock is built when CTRL_LOADUSE_STALL_EN is defined.
module ctrl_decode_pipe #(
    parameter int ALUOP_W = 5,
    parameter int REG_AW  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    input  logic               flush,
    input  logic               syscall_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W+1:0] out_ex,
    output logic [1:0]         out_mem,
    output logic [1:0]         out_wb,
    output logic [REG_AW-1:0]  out_dst,
    output logic               out_jump,
    output logic               out_branch,
    output logic               out_syscall,
    output logic               out_jr,
    output logic               out_jal,
    output logic [2:0]         out_branch_op,
    output logic               out_illegal,
    output logic [31:0]        out_pc,
    output logic               halted
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_MOVZ    = 6'h0A;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_LUI  = 5'b00011;
    localparam logic [4:0] ALU_MFLO = 5'b00100;
    localparam logic [4:0] ALU_MFHI = 5'b00101;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_SLL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;
    localparam logic [4:0] ALU_DIV  = 5'b01010;
    localparam logic [4:0] ALU_MOVZ = 5'b01101;

    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b100;
    localparam logic [2:0] BR_BLTZ = 3'b110;

    typedef enum logic [1:0] {RUN, SYS_WAIT, HALT} state_t;

    // brk is internal only: BREAK leaves the stage as an all-zero bundle.
    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic               mem_to_reg;
        logic [REG_AW-1:0]  dst;
        logic               jump;
        logic               branch;
        logic               syscall;
        logic               jr;
        logic               jal;
        logic [2:0]         branch_op;
        logic               illegal;
        logic               brk;
    } bundle_t;

    function automatic logic [ALUOP_W-1:0] alu(input logic [4:0] code);
        return ALUOP_W'(code);
    endfunction

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign funct  = in_instr[5:0];

    bundle_t     dec, held;
    logic [31:0] held_pc;
    logic        uses_rs, uses_rt, illegal, blank;
    logic        hazard, accept, xfer, flush_eff;
    state_t      state, state_next;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec     = '0;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        illegal = 1'b0;
        blank   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt       = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    FN_SLL:             dec.alu_op = alu(ALU_SLL);
                    FN_SRA:             dec.alu_op = alu(ALU_SRA);
                    FN_MOVZ:            dec.alu_op = alu(ALU_MOVZ);
                    FN_MFHI:            dec.alu_op = alu(ALU_MFHI);
                    FN_MFLO:            dec.alu_op = alu(ALU_MFLO);
                    FN_DIV:             dec.alu_op = alu(ALU_DIV);
                    FN_ADD, FN_ADDU:    dec.alu_op = alu(ALU_ADD);
                    FN_SUB, FN_SUBU:    dec.alu_op = alu(ALU_SUB);
                    FN_AND:             dec.alu_op = alu(ALU_AND);
                    FN_OR:              dec.alu_op = alu(ALU_OR);
                    FN_SLT:             dec.alu_op = alu(ALU_SLT);
                    FN_JR: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.jump      = 1'b1;
                        dec.jr        = 1'b1;
                    end
                    FN_SYSCALL: begin
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                        dec.syscall   = 1'b1;
                    end
                    FN_BREAK:           blank = 1'b1;
                    default:            illegal = 1'b1;
                endcase
                // The all-zero word decodes as SLL $0,$0,0; treat it as a true NOP.
                if (in_instr == 32'h0) begin
                    blank   = 1'b1;
                    uses_rs = 1'b0;
                    uses_rt = 1'b0;
                end
            end
            OP_REGIMM: begin
                if (rt == 5'd0) begin
                    dec.branch    = 1'b1;
                    dec.branch_op = BR_BLTZ;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J: begin
                uses_rs  = 1'b0;
                dec.jump = 1'b1;
            end
            OP_JAL: begin
                uses_rs       = 1'b0;
                dec.jump      = 1'b1;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                uses_rt       = 1'b1;
                dec.branch    = 1'b1;
                dec.branch_op = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                case (opcode)
                    OP_ANDI: dec.alu_op = alu(ALU_AND);
                    OP_ORI:  dec.alu_op = alu(ALU_OR);
                    OP_LUI:  dec.alu_op = alu(ALU_LUI);
                    default: dec.alu_op = alu(ALU_ADD);
                endcase
                if (opcode == OP_LUI) uses_rs = 1'b0;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.alu_op     = alu(ALU_ADD);
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_SW, OP_SB: begin
                uses_rt       = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = alu(ALU_ADD);
                dec.mem_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (dec.reg_dst)  dec.dst = REG_AW'(rd);
        else if (dec.jal) dec.dst = REG_AW'(5'd31);
        else              dec.dst = REG_AW'(rt);

        if (blank) begin
            dec     = '0;
            dec.brk = (in_instr != 32'h0);
        end
        if (illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // A halted stage ignores flush; otherwise flush beats a same-cycle transfer.
    assign flush_eff = flush && (state != HALT);
    assign xfer      = out_valid && out_ready && !flush_eff;
    assign accept    = in_valid && in_ready;

`ifdef CTRL_LOADUSE_STALL_EN
    logic [REG_AW-1:0] load_dst;

    // Zero doubles as "no record": a load to $0 never needs an interlock.
    always_ff @(posedge clk) begin
        if (!rst_n)
            load_dst <= '0;
        else
            load_dst <= (xfer && held.mem_read) ? held.dst : '0;
    end

    assign hazard = (load_dst != '0) &&
                    ((uses_rs && (REG_AW'(rs) == load_dst)) ||
                     (uses_rt && (REG_AW'(rt) == load_dst)));
`else
    logic unused_src;
    assign unused_src = uses_rs ^ uses_rt;
    assign hazard     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            RUN: begin
                in_ready = rst_n && (!out_valid || out_ready) && !flush && !hazard;
                if (xfer && held.syscall)  state_next = SYS_WAIT;
                else if (xfer && held.brk) state_next = HALT;
            end
            SYS_WAIT: if (flush || syscall_done) state_next = RUN;
            HALT:     state_next = HALT;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            held      <= '0;
            held_pc   <= '0;
        end else if (flush_eff) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            held      <= dec;
            held_pc   <= in_pc;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    assign out_ex        = {held.reg_dst, held.alu_src, held.alu_op};
    assign out_mem       = {held.mem_write, held.mem_read};
    assign out_wb        = {held.reg_write, held.mem_to_reg};
    assign out_dst       = held.dst;
    assign out_jump      = held.jump;
    assign out_branch    = held.branch;
    assign out_syscall   = held.syscall;
    assign out_jr        = held.jr;
    assign out_jal       = held.jal;
    assign out_branch_op = held.branch_op;
    assign out_illegal   = held.illegal;
    assign out_pc        = held_pc;
    assign halted        = (state == HALT);

endmodule
